// File: rtl/mux_arbiter_pkg.sv
// Shared flit-type codes, FSM encodings and enable polarity for the output-mux arbiter.
package mux_arbiter_pkg;

  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;
  localparam logic [1:0] TYPE_DATA = 2'b11;

  // Load enables in this block are active-low, matching the trailing-underscore naming.
  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  // Encodings chosen so a LOCK state equals its one-hot mux select.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } state_t;

  function automatic logic [1:0] state_sel(state_t s);
    case (s)
      LOCK0:   return 2'b01;
      LOCK1:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mux_arbiter_rr.sv
// Two-requester round-robin picker; remembers the last port granted.
module rr_arb2
  import mux_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_,
  input  logic [1:0] i_req,
  input  logic       i_ld_,
  output logic [1:0] o_gnt
);

  logic r_last;

  // Lone requester wins outright; on a tie the port not served last wins.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  // Record the winner only when the caller actually takes the grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_)
      r_last <= 1'b1;
    else if (i_ld_ == Enable_)
      r_last <= o_gnt[1];
  end

endmodule

// File: rtl/mux_arbiter.sv
// Wormhole arbiter driving the 2:1 router output mux select.
//   state | meaning
//   IDLE  | no packet locked, arbitrating HEAD requests
//   LOCK0 | input 0 owns the output until TAIL or MAXLEN flits
//   LOCK1 | input 1 owns the output until TAIL or MAXLEN flits
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int MAXLEN = 32
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       ivalid_0,
  input  logic [1:0] itype_0,
  input  logic       ivalid_1,
  input  logic [1:0] itype_1,
  input  logic       ordy,
  output logic [1:0] sel,
  output logic       iack_0,
  output logic       iack_1,
  output logic       busy,
  output logic       err
);

  localparam logic [7:0] MAXLEN_C = 8'(MAXLEN);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_fcnt, w_fcnt_nxt, w_fcnt_inc;
  logic       r_err, w_err_nxt;
  logic [1:0] r_sel;
  logic       r_busy;
  logic [1:0] w_req, w_gnt;
  logic       w_ld_;
  logic       w_xfer;
  logic [1:0] w_xtype;

  assign w_req = {ivalid_1 && (itype_1 == TYPE_HEAD),
                  ivalid_0 && (itype_0 == TYPE_HEAD)};

  rr_arb2 u_rr (
    .i_clk (clk),
    .i_rst_(rst_),
    .i_req (w_req),
    .i_ld_ (w_ld_),
    .o_gnt (w_gnt)
  );

  // Acks come from the registered select so itype never reaches sel combinationally.
  assign iack_0     = r_sel[0] && ivalid_0 && ordy;
  assign iack_1     = r_sel[1] && ivalid_1 && ordy;
  assign w_xfer     = iack_0 || iack_1;
  assign w_xtype    = r_sel[1] ? itype_1 : itype_0;
  assign w_fcnt_inc = r_fcnt + 8'd1;

  // Next state: grant in IDLE, release on TAIL or on the MAXLEN-th non-TAIL flit.
  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    w_err_nxt   = 1'b0;
    w_ld_       = Disable_;
    case (r_state)
      IDLE: begin
        w_fcnt_nxt = 8'd0;
        if (w_gnt != 2'b00) begin
          w_ld_       = Enable_;
          w_state_nxt = w_gnt[1] ? LOCK1 : LOCK0;
        end
      end
      LOCK0, LOCK1: begin
        if (w_xfer) begin
          w_fcnt_nxt = w_fcnt_inc;
          if (w_xtype == TYPE_TAIL) begin
            w_state_nxt = IDLE;
          end else if (w_fcnt_inc == MAXLEN_C) begin
            w_state_nxt = IDLE;
            w_err_nxt   = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, flit count and registered outputs, all with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state <= IDLE;
      r_fcnt  <= 8'd0;
      r_err   <= 1'b0;
      r_sel   <= 2'b00;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_err   <= w_err_nxt;
      r_sel   <= state_sel(w_state_nxt);
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign sel  = r_sel;
  assign busy = r_busy;
  assign err  = r_err;

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter; a second instance with MAXLEN=4 covers forced release.
module tb_mux_arbiter;
  import mux_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       ivalid_0 = 1'b0, ivalid_1 = 1'b0, ordy = 1'b1;
  logic [1:0] itype_0 = 2'b00, itype_1 = 2'b00;
  logic [1:0] sel, sel4;
  logic       iack_0, iack_1, busy, err;
  logic       iack4_0, iack4_1, busy4, err4;

  bit         use4 = 1'b0;
  logic [1:0] t_sel;
  logic       t_iack_0, t_iack_1, t_busy, t_err;

  int         n_vec = 0, n_err = 0;
  logic [1:0] q0[$], q1[$];
  int         ack0 = 0, ack1 = 0, errs = 0, bad = 0;
  bit         grants[$];
  logic [1:0] prev_sel = 2'b00;
  bit         ordy_v = 1'b1;
  int         n;

  always #5 clk = ~clk;

  mux_arbiter #(.MAXLEN(32)) dut (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .ordy(ordy), .sel(sel), .iack_0(iack_0), .iack_1(iack_1),
    .busy(busy), .err(err)
  );

  mux_arbiter #(.MAXLEN(4)) dut4 (
    .clk(clk), .rst_(rst_),
    .ivalid_0(ivalid_0), .itype_0(itype_0),
    .ivalid_1(ivalid_1), .itype_1(itype_1),
    .ordy(ordy), .sel(sel4), .iack_0(iack4_0), .iack_1(iack4_1),
    .busy(busy4), .err(err4)
  );

  assign t_sel    = use4 ? sel4    : sel;
  assign t_iack_0 = use4 ? iack4_0 : iack_0;
  assign t_iack_1 = use4 ? iack4_1 : iack_1;
  assign t_busy   = use4 ? busy4   : busy;
  assign t_err    = use4 ? err4    : err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: present queue heads, sample acks before the edge, pop acked flits.
  task automatic cycle();
    logic a0, a1;
    ivalid_0 = (q0.size() != 0);
    itype_0  = (q0.size() != 0) ? q0[0] : TYPE_NONE;
    ivalid_1 = (q1.size() != 0);
    itype_1  = (q1.size() != 0) ? q1[0] : TYPE_NONE;
    ordy     = ordy_v;
    #1;
    a0 = t_iack_0;
    a1 = t_iack_1;
    if (a0) ack0++;
    if (a1) ack1++;
    if ((a0 && t_sel != 2'b01) || (a1 && t_sel != 2'b10)) bad++;
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    if (t_sel != 2'b00 && prev_sel == 2'b00) grants.push_back(t_sel[1]);
    prev_sel = t_sel;
    if (t_err) errs++;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    q0.delete();
    q1.delete();
    ordy_v = 1'b1;
    repeat (2) cycle();
    rst_ = 1'b1;
    ack0 = 0; ack1 = 0; errs = 0; bad = 0;
    grants.delete();
    prev_sel = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;

    // Reset state
    do_reset();
    chk("rst_sel", sel, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_fcnt", dut.r_fcnt, 8'd0);

    // Single packet on input 0: HEAD, 20 DATA, TAIL
    q0.push_back(TYPE_HEAD);
    repeat (20) q0.push_back(TYPE_DATA);
    q0.push_back(TYPE_TAIL);
    cycle();
    chk("t1_sel_grant", sel, 2'b01);
    chk("t1_busy", busy, 1'b1);
    repeat (22) cycle();
    chk("t1_sel_rel", sel, 2'b00);
    chk("t1_busy_rel", busy, 1'b0);
    chk("t1_acks", ack0, 22);
    chk("t1_errs", errs, 0);
    chk("t1_drained", q0.size(), 0);

    // Simultaneous HEADs after reset: input 0 first, bubble, then input 1
    do_reset();
    q0 = '{TYPE_HEAD, TYPE_DATA, TYPE_DATA, TYPE_TAIL};
    q1 = '{TYPE_HEAD, TYPE_DATA, TYPE_TAIL};
    cycle();
    chk("t2_tie_sel", sel, 2'b01);
    repeat (4) cycle();
    chk("t2_bubble_sel", sel, 2'b00);
    chk("t2_ack0", ack0, 4);
    chk("t2_ack1_mid", ack1, 0);
    cycle();
    chk("t2_sel1", sel, 2'b10);
    repeat (3) cycle();
    chk("t2_sel_end", sel, 2'b00);
    chk("t2_ack1", ack1, 3);

    // Ten back-to-back packets per input: strict alternation, one bubble each
    ack0 = 0; ack1 = 0; bad = 0;
    grants.delete();
    prev_sel = sel;
    repeat (10) begin
      q0.push_back(TYPE_HEAD); q0.push_back(TYPE_DATA); q0.push_back(TYPE_TAIL);
      q1.push_back(TYPE_HEAD); q1.push_back(TYPE_DATA); q1.push_back(TYPE_TAIL);
    end
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      cycle();
      n++;
    end
    chk("t3_cycles", n, 80);
    chk("t3_grants", grants.size(), 20);
    for (int i = 0; i < 20 && i < grants.size(); i++)
      chk($sformatf("t3_grant%0d", i), grants[i], i % 2);
    chk("t3_ack0", ack0, 30);
    chk("t3_ack1", ack1, 30);
    chk("t3_wrong_port_acks", bad, 0);
    chk("t3_sel_end", sel, 2'b00);

    // Downstream stall mid-packet on input 1
    ack1 = 0;
    q1.push_back(TYPE_HEAD);
    repeat (5) q1.push_back(TYPE_DATA);
    q1.push_back(TYPE_TAIL);
    cycle();
    chk("t4_sel", sel, 2'b10);
    repeat (3) cycle();
    chk("t4_fcnt_pre", dut.r_fcnt, 8'd3);
    ordy_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk($sformatf("t4_stall_sel%0d", i), sel, 2'b10);
    end
    chk("t4_stall_acks", ack1, 3);
    chk("t4_fcnt_frozen", dut.r_fcnt, 8'd3);
    ordy_v = 1'b1;
    repeat (4) cycle();
    chk("t4_sel_end", sel, 2'b00);
    chk("t4_acks", ack1, 7);
    chk("t4_drained", q1.size(), 0);

    // MAXLEN=4 instance: HEAD + 6 DATA, no TAIL; input 1 HEAD waiting
    use4 = 1'b1;
    do_reset();
    q0.push_back(TYPE_HEAD);
    repeat (6) q0.push_back(TYPE_DATA);
    q1 = '{TYPE_HEAD, TYPE_TAIL};
    cycle();
    chk("t5_sel", t_sel, 2'b01);
    repeat (4) cycle();
    chk("t5_rel_sel", t_sel, 2'b00);
    chk("t5_err", t_err, 1'b1);
    chk("t5_busy", t_busy, 1'b0);
    chk("t5_ack0", ack0, 4);
    cycle();
    chk("t5_next_sel", t_sel, 2'b10);
    chk("t5_err_pulse", t_err, 1'b0);
    chk("t5_no_idle_ack", ack0, 4);
    repeat (3) cycle();
    chk("t5_end_sel", t_sel, 2'b00);
    chk("t5_ack1", ack1, 2);
    chk("t5_errs", errs, 1);
    chk("t5_data_ignored", ack0, 4);
    use4 = 1'b0;

    // One-cycle reset while LOCK1, then a tie
    do_reset();
    q1 = '{TYPE_HEAD, TYPE_DATA, TYPE_DATA, TYPE_DATA, TYPE_TAIL};
    cycle();
    chk("t6_sel_lock1", sel, 2'b10);
    repeat (2) cycle();
    rst_ = 1'b0;
    cycle();
    rst_ = 1'b1;
    chk("t6_sel", sel, 2'b00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_err", err, 1'b0);
    chk("t6_fcnt", dut.r_fcnt, 8'd0);
    q0 = '{TYPE_HEAD, TYPE_TAIL};
    q1 = '{TYPE_HEAD, TYPE_TAIL};
    ack0 = 0; ack1 = 0;
    cycle();
    chk("t6_tie_sel", sel, 2'b01);
    repeat (3) cycle();
    chk("t6_sel1", sel, 2'b10);
    repeat (2) cycle();
    chk("t6_sel_end", sel, 2'b00);
    chk("t6_ack0", ack0, 2);
    chk("t6_ack1", ack1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Packet-level (wormhole) arbiter that drives the select of the 2:1 router output mux. It watches the valid/flit-type of both mux inputs, grants one input per packet in round-robin order, and holds the grant from HEAD through TAIL. The granted input's flits then stream through the mux to the single output, subject to downstream ready. It sits beside the `mux` instance inside the router output stage.

## Interface
- `MAXLEN`, 32: maximum flits per packet (HEAD..TAIL inclusive) before forced release; 2..255.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_`  in  1  synchronous, active-low reset.
- `ivalid_0`  in  1  flit valid on mux input 0.
- `itype_0`  in  2  flit type of input 0 (top two bits of `idata_0`).
- `ivalid_1`  in  1  flit valid on mux input 1.
- `itype_1`  in  2  flit type of input 1.
- `ordy`  in  1  downstream accepts a flit this cycle.
- `sel`  out  2  one-hot mux select: 2'b01 input 0, 2'b10 input 1, 2'b00 none; registered.
- `iack_0`  out  1  flit on input 0 consumed this cycle (combinational).
- `iack_1`  out  1  flit on input 1 consumed this cycle (combinational).
- `busy`  out  1  a packet is locked; registered.
- `err`  out  1  one-cycle pulse on forced release; registered.

## Operation
- States: IDLE, LOCK0, LOCK1. `sel` = 01 in LOCK0, 10 in LOCK1, 00 in IDLE; `busy` = (state != IDLE).
- Request k: `ivalid_k` && `itype_k` == HEAD. Non-HEAD valid flits in IDLE are not requests; they are ignored (no ack).
- IDLE: one request → LOCK that port. Two requests → port ≠ `last` (round-robin). No request → stay.
- `last` (1 bit) updates to the granted port on each IDLE→LOCK transition. Reset value 1, so port 0 wins the first tie.
- Transfer in LOCKk: `ivalid_k` && `ordy`; `iack_k` = transfer; other `iack` = 0. In IDLE both acks are 0.
- `fcnt` (8 bit) counts transfers in the current packet. It clears on entering LOCK and increments on each transfer.
- LOCKk → IDLE when a TAIL transfer occurs.
- LOCKk → IDLE with `err` = 1 next cycle when a non-TAIL transfer makes `fcnt` reach `MAXLEN`.
- A HEAD seen while locked is counted as a data flit. No re-arbitration happens mid-packet.
- `ivalid_k` low or `ordy` low while locked: hold the lock, no count change. This is wormhole behaviour with no timeout on stalls.
- TAIL transfer and `fcnt` reaching `MAXLEN` in the same cycle: normal release, `err` = 0.
- Reset (any state, any cycle): state IDLE, `sel` 00, `busy` 0, `err` 0, `fcnt` 0, `last` 1.

## Timing
- Arbitration latency: HEAD valid at cycle t in IDLE → `sel` valid at t+1 → first `iack` at t+1 if `ordy`.
- Release: TAIL acked at t → `sel` 00 at t+1; next grant earliest at t+2. This is one idle bubble between packets, even on the same port.
- `iack_k` depends combinationally on registered `sel` plus `ivalid_k`/`ordy`. No combinational path from `itype` to `sel`.
- `err` is high exactly one cycle, coincident with `sel` = 00.

## Structure
- Shared define file holds `TYPE_NONE`=2'b00, `TYPE_HEAD`=2'b01, `TYPE_TAIL`=2'b10, `TYPE_DATA`=2'b11. It also holds the state encodings IDLE/LOCK0/LOCK1 and `Enable_`/`Disable_`.
- One sub-module: `rr_arb2`, a 2-requester round-robin picker with a `last` register and a load-enable.
- The top holds the FSM, `fcnt`, the ack logic and the `err` register.

## Test plan
- Single packet on input 0 (HEAD, 20 DATA, TAIL; `ordy`=1): `sel`=01 one cycle after HEAD. 22 `iack_0` pulses, then `sel`=00 and `busy`=0; `err` stays 0.
- Simultaneous HEADs on both inputs after reset: input 0 packet completes first. `sel`=00 for one cycle, then `sel`=10 and input 1 packet completes.
- Continuous HEAD traffic on both inputs for 10 packets each: grants strictly alternate 0,1,0,1…; zero `iack` on the non-granted port.
- `ordy` low for 5 cycles mid-packet on input 1: `sel` stays 10, no `iack_1`, `fcnt` frozen; resumes on `ordy`=1 with no lost flit.
- `MAXLEN`=4, input 0 sends HEAD + 6 DATA with no TAIL: release after 4th transfer, `err`=1 for one cycle. The following input 1 HEAD is granted two cycles later.
- Assert `rst_`=0 for one cycle during LOCK1: next cycle `sel`=00, `busy`=0, `err`=0. After reset, a tie goes to input 0.
